intersection_phase_arbiter: RTL
===============================

Name: intersection_phase_arbiter

Overview:
- Round-robin green-phase scheduler that shares one intersection between N_APPR approaches; only one approach is ever GREEN or YELLOW.
- Generalises the two-road highway/country controller to N sensor-driven requesters with min/max green, yellow and all-red clearance, plus emergency preemption.
- Sits between the road sensors / preempt receiver and the lamp drivers; approach 0 is the home (main road) phase.

Parameters:
- N_APPR, 4, number of approaches (2..8).
- MIN_GREEN, 4, minimum green cycles before a non-preempt change.
- MAX_GREEN, 10, green cycles after which a still-requesting phase is forced off if another approach waits.
- YELLOW_T, 3, yellow cycles.
- ALLRED_T, 2, all-red clearance cycles.
- TW, 5, timer width; all timing parameters must be at most 2^TW-1.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- req  in  N_APPR  level car-present sensors, one bit per approach.
- preempt  in  1  emergency preempt request (level).
- preempt_id  in  clog2(N_APPR)  approach to serve under preempt.
- light  out  2*N_APPR  lamp code per approach, slice i = light[2i+1:2i]; RED=0, YELLOW=1, GREEN=2.
- grant  out  N_APPR  one-hot owner of the current phase; all zero in ALLRED.
- phase_done  out  1  single-cycle pulse on the cycle ALLRED hands over to the next GREEN.

Behaviour:
- Registered state: st (GREEN/YELLOW/ALLRED), cur (owner), nxt (latched successor), tmr (TW bits).
- light, grant and phase_done are combinational decodes of the registered state.
- Reset (clear=0, async): st=GREEN, cur=0, nxt=0, tmr=0, light=approach 0 GREEN with all others RED, grant=0...01, phase_done=0.

Successor selection:
- sel = first i with req[i]=1, scanning cur+1, cur+2, ... modulo N_APPR and excluding cur.
- If no other approach requests, sel=0 (home).

GREEN:
- tmr increments each cycle and saturates at 2^TW-1.
- Leave to YELLOW (tmr<=0, nxt<=sel, or nxt<=preempt_id when preempting) at the first edge where one of these holds:
  - (a) preempt=1 and preempt_id!=cur; MIN_GREEN is ignored.
  - (b) preempt=0, tmr>=MIN_GREEN-1, another approach requests, and (req[cur]=0 or tmr>=MAX_GREEN-1).
  - (c) preempt=0, cur!=0, tmr>=MIN_GREEN-1, req[cur]=0 and no other request; then nxt=0 (return home).
- cur=0 with no other request stays GREEN indefinitely.
- preempt=1 with preempt_id==cur holds GREEN; no max-out occurs.

YELLOW:
- Lasts YELLOW_T cycles (tmr 0..YELLOW_T-1); then st<=ALLRED, tmr<=0.
- preempt asserted during YELLOW overrides nxt<=preempt_id; the clearance is never shortened.

ALLRED:
- All lights RED for ALLRED_T cycles; preempt overrides nxt the same way as in YELLOW.
- On exit: cur<=nxt, st<=GREEN, tmr<=0, phase_done=1 for that one cycle.

Invariants and boundaries:
- At most one slice is non-RED at any time.
- GREEN never shows simultaneously with another approach's YELLOW.
- A req pulse shorter than one cycle that is not sampled during GREEN is lost; sensors are level and there is no request latching.
- An out-of-range preempt_id (>=N_APPR) is ignored, treated as preempt=0.
- clear asserted mid-phase immediately forces the reset values; there is no clearance on reset.

Decomposition:
- Shared package traffic_pkg holds light codes RED/YELLOW/GREEN, phase state encodings, and default timing constants shared with the two-road controller.
- One sub-module, phase_timer: a TW-bit up-counter with sync restart, saturation, and a compare output against a loaded limit. It replaces the ad-hoc timer and is reused by the two-road controller.

Test Plan:
- Reset / idle: hold clear=0 for 3 cycles, release with req=0 -> light=0x02 (approach 0 GREEN, others RED), grant=0001, stable for 50 cycles.
- Single request: req=0100 from cycle 0 after reset -> approach 0 GREEN 4 cycles, YELLOW 3, all-red 2, then light[5:4]=GREEN, grant=0100, phase_done pulses once.
- Max-out and round robin: req=1111 held -> each approach gets exactly 10 green cycles in order 0,1,2,3,0 with 5-cycle clearance between them; the order never skips an approach.
- Early release and return home: approach 2 green, drop req[2] at its tmr=1 with no other req -> green lasts exactly 4 cycles, then the sequence returns to approach 0.
- Preempt: approach 1 green at tmr=0, assert preempt with preempt_id=3 -> YELLOW on the next edge, full 3+2 clearance, then approach 3 GREEN held while preempt=1 even with req=0111.
- Reset mid-YELLOW: pull clear low -> outputs immediately revert to approach 0 GREEN, tmr=0, no phase_done pulse.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controllers: lamp codes, phase
// state encoding and default timing constants.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } phase_t;

    localparam logic [1:0] LIGHT_RED    = 2'd0;
    localparam logic [1:0] LIGHT_YELLOW = 2'd1;
    localparam logic [1:0] LIGHT_GREEN  = 2'd2;

    localparam int DEF_MIN_GREEN = 4;
    localparam int DEF_MAX_GREEN = 10;
    localparam int DEF_YELLOW_T  = 3;
    localparam int DEF_ALLRED_T  = 2;
    localparam int DEF_TW        = 5;

endpackage

// File: rtl/phase_timer.sv
// Saturating up-counter with synchronous restart and a >= compare against a
// caller-supplied limit; shared by the phase controllers.
module phase_timer #(
    parameter int TW = 5
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          restart,
    input  logic [TW-1:0] limit,
    output logic [TW-1:0] count,
    output logic          at_limit
);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + TW'(1);
        end
    end

    assign at_limit = (count >= limit);

endmodule

// File: rtl/intersection_phase_arbiter.sv
// Round-robin green-phase scheduler for N_APPR approaches with min/max green,
// yellow, all-red clearance and emergency preemption. Approach 0 is home.
module intersection_phase_arbiter
    import traffic_pkg::*;
#(
    parameter int N_APPR    = 4,
    parameter int MIN_GREEN = DEF_MIN_GREEN,
    parameter int MAX_GREEN = DEF_MAX_GREEN,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T,
    parameter int TW        = DEF_TW
) (
    input  logic                        clock,
    input  logic                        clear,
    input  logic [N_APPR-1:0]           req,
    input  logic                        preempt,
    input  logic [$clog2(N_APPR)-1:0]   preempt_id,
    output logic [2*N_APPR-1:0]         light,
    output logic [N_APPR-1:0]           grant,
    output logic                        phase_done,
    output logic [1:0]                  state_dbg
);

    localparam int IDW = $clog2(N_APPR);

    localparam logic [TW-1:0] MIN_LIM = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_LIM = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_LIM = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR_LIM  = TW'(ALLRED_T - 1);

    phase_t         st, st_d;
    logic [IDW-1:0] cur, cur_d;
    logic [IDW-1:0] nxt, nxt_d;
    logic [TW-1:0]  tmr;
    logic [TW-1:0]  limit;
    logic           at_limit;
    logic           restart;

    logic           pre_ok;
    logic [IDW-1:0] sel;
    logic           other_req;
    int             scan_idx;

    phase_timer #(.TW(TW)) u_timer (
        .clock    (clock),
        .clear    (clear),
        .restart  (restart),
        .limit    (limit),
        .count    (tmr),
        .at_limit (at_limit)
    );

    // An out-of-range preempt_id behaves as if no preempt were asserted.
    assign pre_ok = preempt && (int'(preempt_id) < N_APPR);

    // Scan backwards so the last hit written is the first one after cur.
    always_comb begin
        sel       = '0;
        other_req = 1'b0;
        scan_idx  = 0;
        for (int k = N_APPR - 1; k >= 1; k--) begin
            scan_idx = (int'(cur) + k) % N_APPR;
            if (req[scan_idx]) begin
                sel       = IDW'(scan_idx);
                other_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            st  <= ST_GREEN;
            cur <= '0;
            nxt <= '0;
        end else begin
            st  <= st_d;
            cur <= cur_d;
            nxt <= nxt_d;
        end
    end

    always_comb begin
        st_d    = st;
        cur_d   = cur;
        nxt_d   = nxt;
        restart = 1'b0;
        limit   = MIN_LIM;
        unique case (st)
            ST_GREEN: begin
                limit = MIN_LIM;
                if (pre_ok && (preempt_id != cur)) begin
                    st_d    = ST_YELLOW;
                    nxt_d   = preempt_id;
                    restart = 1'b1;
                end else if (!pre_ok && at_limit && other_req &&
                             (!req[cur] || (tmr >= MAX_LIM))) begin
                    st_d    = ST_YELLOW;
                    nxt_d   = sel;
                    restart = 1'b1;
                end else if (!pre_ok && at_limit && (cur != '0) &&
                             !req[cur] && !other_req) begin
                    st_d    = ST_YELLOW;
                    nxt_d   = '0;
                    restart = 1'b1;
                end
            end
            ST_YELLOW: begin
                limit = YEL_LIM;
                if (pre_ok) nxt_d = preempt_id;
                if (at_limit) begin
                    st_d    = ST_ALLRED;
                    restart = 1'b1;
                end
            end
            ST_ALLRED: begin
                limit = AR_LIM;
                if (pre_ok) nxt_d = preempt_id;
                if (at_limit) begin
                    st_d    = ST_GREEN;
                    cur_d   = pre_ok ? preempt_id : nxt;
                    restart = 1'b1;
                end
            end
            default: begin
                st_d    = ST_GREEN;
                restart = 1'b1;
            end
        endcase
    end

    always_comb begin
        light = '0;
        grant = '0;
        for (int i = 0; i < N_APPR; i++) begin
            if (IDW'(i) == cur) begin
                if (st == ST_GREEN)  light[2*i +: 2] = LIGHT_GREEN;
                if (st == ST_YELLOW) light[2*i +: 2] = LIGHT_YELLOW;
                if (st != ST_ALLRED) grant[i] = 1'b1;
            end
        end
    end

    assign phase_done = (st == ST_ALLRED) && at_limit;
    assign state_dbg  = st;

endmodule
